// File: rtl/frame_config_writer.sv
// Configuration-port driver: receives header + row words, assembles a frame on
// FrameData, then pulses one FrameStrobe bit for the addressed column/frame.
module frame_config_writer #(
    parameter int unsigned NumColumns      = 4,
    parameter int unsigned NumRows         = 4,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned StrobeCycles    = 1,
    parameter logic [15:0] SyncWord        = 16'hFAB0
) (
    input  logic                                   UserCLK,
    input  logic                                   reset,
    input  logic [FrameBitsPerRow-1:0]             s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                   busy,
    output logic                                   err_sync,
    output logic                                   err_range,
    output logic [15:0]                            frames_written
);

    localparam int unsigned DataW = NumRows * FrameBitsPerRow;
    localparam int unsigned StrbW = NumColumns * MaxFramesPerCol;
    localparam int unsigned RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned CntW  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        DISCARD = 3'd2,
        STROBE  = 3'd3,
        GAP     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [RowW-1:0]   row_cnt_q, row_cnt_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        frame_q, frame_d;
    logic [DataW-1:0]  data_q, data_d;
    logic [StrbW-1:0]  strobe_q, strobe_d;
    logic [CntW-1:0]   scnt_q, scnt_d;
    logic [15:0]       fw_q, fw_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              err_sync_q, err_sync_d;
    logic              err_range_q, err_range_d;

    logic              xfer;
    logic [15:0]       hdr_sync;
    logic [7:0]        hdr_col;
    logic [7:0]        hdr_frame;
    logic [31:0]       strobe_idx;
    logic              last_row;

    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            data_q      <= '0;
            strobe_q    <= '0;
            scnt_q      <= '0;
            fw_q        <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_sync_q  <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            scnt_q      <= scnt_d;
            fw_q        <= fw_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            err_sync_q  <= err_sync_d;
            err_range_q <= err_range_d;
        end
    end

    // Next-state and next-output logic; strobe is rebuilt from scratch every cycle.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_d       = col_q;
        frame_d     = frame_q;
        data_d      = data_q;
        strobe_d    = '0;
        scnt_d      = scnt_q;
        fw_d        = fw_q;
        err_sync_d  = 1'b0;
        err_range_d = 1'b0;

        xfer       = s_valid && s_ready_q;
        hdr_sync   = s_data[31:16];
        hdr_col    = s_data[15:8];
        hdr_frame  = s_data[7:0];
        strobe_idx = 32'(col_q) * 32'(MaxFramesPerCol) + 32'(frame_q);
        last_row   = (row_cnt_q == RowW'(NumRows - 1));

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_sync != SyncWord) begin
                        err_sync_d = 1'b1;
                    end else if ((32'(hdr_col) >= NumColumns) ||
                                 (32'(hdr_frame) >= MaxFramesPerCol)) begin
                        err_range_d = 1'b1;
                        row_cnt_d   = '0;
                        state_d     = DISCARD;
                    end else begin
                        col_d     = hdr_col;
                        frame_d   = hdr_frame;
                        row_cnt_d = '0;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    data_d[row_cnt_q*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    if (last_row) begin
                        row_cnt_d = '0;
                        scnt_d    = CntW'(StrobeCycles);
                        strobe_d  = StrbW'(1) << strobe_idx;
                        state_d   = STROBE;
                    end else begin
                        row_cnt_d = row_cnt_q + RowW'(1);
                    end
                end
            end
            DISCARD: begin
                if (xfer) begin
                    if (last_row) begin
                        row_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + RowW'(1);
                    end
                end
            end
            STROBE: begin
                if (scnt_q > CntW'(1)) begin
                    scnt_d   = scnt_q - CntW'(1);
                    strobe_d = strobe_q;
                end else begin
                    fw_d    = fw_q + 16'd1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DISCARD);
        busy_d    = (state_d != IDLE);
    end

    assign s_ready        = s_ready_q;
    assign FrameData      = data_q;
    assign FrameStrobe    = strobe_q;
    assign busy           = busy_q;
    assign err_sync       = err_sync_q;
    assign err_range      = err_range_q;
    assign frames_written = fw_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed self-checking bench for frame_config_writer (strobe widths 1 and 3).
module tb_frame_config_writer;

    logic          UserCLK = 1'b0;
    logic          reset;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [127:0]  FrameData;
    logic [79:0]   FrameStrobe;
    logic          busy, err_sync, err_range;
    logic [15:0]   frames_written;

    logic [31:0]   b_data;
    logic          b_valid;
    logic          b_ready;
    logic [127:0]  b_fd;
    logic [79:0]   b_strobe;
    logic          b_busy, b_es, b_er;
    logic [15:0]   b_fw;

    int n_checks = 0;
    int n_errors = 0;
    int str_hi = 0;
    int rdy_lo = 0;
    int bad_strobe = 0;
    logic          prev_hi = 1'b0;
    logic [127:0]  prev_fd = '0;
    logic [79:0]   exp_strobe = '0;
    logic [79:0]   one80 = 80'd1;

    always #5 UserCLK = ~UserCLK;

    frame_config_writer dut_a (
        .UserCLK(UserCLK), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .busy(busy), .err_sync(err_sync), .err_range(err_range),
        .frames_written(frames_written)
    );

    frame_config_writer #(.StrobeCycles(3)) dut_b (
        .UserCLK(UserCLK), .reset(reset), .s_data(b_data), .s_valid(b_valid),
        .s_ready(b_ready), .FrameData(b_fd), .FrameStrobe(b_strobe),
        .busy(b_busy), .err_sync(b_es), .err_range(b_er),
        .frames_written(b_fw)
    );

    // Track strobe activity of dut_a: width, one-hot target, data stability.
    always @(negedge UserCLK) begin
        if (!reset) begin
            if (FrameStrobe != '0 && FrameStrobe != exp_strobe) bad_strobe++;
            if (FrameStrobe != '0 && prev_hi && FrameData != prev_fd) bad_strobe++;
            if (FrameStrobe != '0) str_hi++;
            if (!s_ready) rdy_lo++;
            prev_hi = (FrameStrobe != '0);
            prev_fd = FrameData;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one word at a negedge; returns at the negedge after it transfers.
    task automatic send(input logic [31:0] w);
        int t;
        s_data  = w;
        s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 20) begin
            @(negedge UserCLK);
            t++;
        end
        if (t >= 20) check("send_timeout", 128'd0, 128'd1);
        @(posedge UserCLK);
        @(negedge UserCLK);
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge UserCLK);
    endtask

    int snap_hi, snap_lo, b_cnt, b_bad;
    logic [31:0] b_rows [4];

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; b_valid = 1'b0; b_data = '0;
        repeat (3) @(negedge UserCLK);
        check("rst_ready", 128'(s_ready), 128'd0);
        check("rst_data", FrameData, 128'd0);
        check("rst_strobe", 128'(FrameStrobe), 128'd0);
        check("rst_fw", 128'(frames_written), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        reset = 1'b0;
        @(negedge UserCLK);
        check("ready_after_rst", 128'(s_ready), 128'd1);

        // Basic frame: col 2, frame 3 -> strobe bit 43
        snap_hi = str_hi; snap_lo = rdy_lo;
        exp_strobe = one80 << 43;
        send(32'hFAB0_0203);
        check("busy_load", 128'(busy), 128'd1);
        send(32'h1111_1111); send(32'h2222_2222); send(32'h3333_3333); send(32'h4444_4444);
        s_valid = 1'b0;
        check("t1_strobe", 128'(FrameStrobe), 128'(one80 << 43));
        check("t1_ready_strobe", 128'(s_ready), 128'd0);
        check("t1_data", FrameData, 128'h44444444_33333333_22222222_11111111);
        @(negedge UserCLK);
        check("t1_gap_strobe", 128'(FrameStrobe), 128'd0);
        check("t1_gap_ready", 128'(s_ready), 128'd0);
        check("t1_fw", 128'(frames_written), 128'd1);
        @(negedge UserCLK);
        check("t1_ready_back", 128'(s_ready), 128'd1);
        check("t1_busy_idle", 128'(busy), 128'd0);
        check("t1_strobe_cycles", 128'(str_hi - snap_hi), 128'd1);
        check("t1_ready_low", 128'(rdy_lo - snap_lo), 128'd2);

        // Sync error, then range errors with discarded payloads
        snap_hi = str_hi;
        send(32'hFAB1_0000);
        s_valid = 1'b0;
        check("sync_err", 128'(err_sync), 128'd1);
        check("sync_busy", 128'(busy), 128'd0);
        @(negedge UserCLK);
        check("sync_err_pulse", 128'(err_sync), 128'd0);
        send(32'hFAB0_0400);
        s_valid = 1'b0;
        check("range_col", 128'(err_range), 128'd1);
        check("range_col_busy", 128'(busy), 128'd1);
        send(32'hDEAD_0001); send(32'hDEAD_0002); send(32'hDEAD_0003);
        check("discard_busy3", 128'(busy), 128'd1);
        send(32'hDEAD_0004);
        s_valid = 1'b0;
        check("discard_done", 128'(busy), 128'd0);
        send(32'hFAB0_0014);
        s_valid = 1'b0;
        check("range_frame", 128'(err_range), 128'd1);
        @(negedge UserCLK);
        check("range_pulse", 128'(err_range), 128'd0);
        for (int i = 0; i < 4; i++) send(32'hBEEF_0000 + 32'(i));
        s_valid = 1'b0;
        check("discard2_done", 128'(busy), 128'd0);
        check("err_data_kept", FrameData, 128'h44444444_33333333_22222222_11111111);
        check("err_fw_kept", 128'(frames_written), 128'd1);
        check("err_no_strobe", 128'(str_hi - snap_hi), 128'd0);

        // StrobeCycles=3 instance with s_valid toggling every cycle
        b_rows[0] = 32'h0101_0101; b_rows[1] = 32'h0202_0202;
        b_rows[2] = 32'h0303_0303; b_rows[3] = 32'h0404_0404;
        b_data = 32'hFAB0_0000; b_valid = 1'b1;
        @(negedge UserCLK);
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge UserCLK);
            check("b_ready_row", 128'(b_ready), 128'd1);
            b_data = b_rows[i]; b_valid = 1'b1;
            @(negedge UserCLK);
            b_valid = 1'b0; b_data = 32'hFFFF_FFFF;
        end
        b_cnt = 0; b_bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (b_strobe != '0) b_cnt++;
            if (b_strobe != '0 && b_strobe != one80) b_bad++;
            if (k < 4) @(negedge UserCLK);
        end
        check("b_ready_back", 128'(b_ready), 128'd1);
        check("b_strobe_cycles", 128'(b_cnt), 128'd3);
        check("b_strobe_other", 128'(b_bad), 128'd0);
        check("b_data", b_fd, 128'h04040404_03030303_02020202_01010101);
        check("b_fw", 128'(b_fw), 128'd1);

        // Reset asserted while strobing
        exp_strobe = one80 << 25;
        send(32'hFAB0_0105);
        send(32'hA0A0_A0A0); send(32'hB1B1_B1B1); send(32'hC2C2_C2C2); send(32'hD3D3_D3D3);
        s_valid = 1'b0;
        check("pre_rst_strobe", 128'(FrameStrobe), 128'(one80 << 25));
        #1 reset = 1'b1;
        #1;
        check("mid_rst_strobe", 128'(FrameStrobe), 128'd0);
        check("mid_rst_data", FrameData, 128'd0);
        check("mid_rst_fw", 128'(frames_written), 128'd0);
        check("mid_rst_ready", 128'(s_ready), 128'd0);
        @(negedge UserCLK);
        reset = 1'b0;
        @(negedge UserCLK);
        exp_strobe = one80 << 21;
        send(32'hFAB0_0101);
        send(32'h0000_0001); send(32'h0000_0002); send(32'h0000_0003); send(32'h0000_0004);
        idle_cycles(2);
        check("post_rst_fw", 128'(frames_written), 128'd1);
        check("post_rst_data", FrameData, 128'h00000004_00000003_00000002_00000001);

        // Counter wrap from 16'hFFFF
        force dut_a.fw_q = 16'hFFFF;
        #1 release dut_a.fw_q;
        @(negedge UserCLK);
        check("fw_preload", 128'(frames_written), 128'hFFFF);
        exp_strobe = one80 << 79;
        send(32'hFAB0_0313);
        send(32'h5555_5555); send(32'h6666_6666); send(32'h7777_7777); send(32'h8888_8888);
        idle_cycles(2);
        check("fw_wrap", 128'(frames_written), 128'd0);
        check("wrap_data", FrameData, 128'h88888888_77777777_66666666_55555555);

        check("strobe_onehot_stable", 128'(bad_strobe), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
